context_switch_ctrl: RTL and testbench

//   Sequences switches between the OS register context (bank 0) and the user-program context
//   (bank 1) of the 64-entry dual-context register bank. Owns select_proc_reg_read/write,

---
 rtl/context_switch_ctrl.sv | 137 +++++++++++++
 tb/tb_context_switch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/context_switch_ctrl.sv
// Context-switch sequencer for the dual-context register bank: OS <-> user program,
// with a preemption quantum and fetch stall/redirect on every switch.
module context_switch_ctrl #(
  parameter int          QW          = 16,
  parameter int          DEF_QUANTUM = 1000,
  parameter logic [31:0] OS_VECTOR   = 32'd0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ResumeProc,
  input  logic [31:0]   ResumeAddr,
  input  logic [QW-1:0] QuantumIn,
  input  logic [31:0]   ProgramCounter,
  input  logic          Syscall,
  input  logic          EndProcIn,
  output logic          Stall,
  output logic          PcLoad,
  output logic [31:0]   PcTarget,
  output logic [31:0]   SavedPc,
  output logic          select_proc_reg_read,
  output logic          select_proc_reg_write,
  output logic          change_so,
  output logic          end_proc,
  output logic          WriteGate,
  output logic [QW-1:0] QuantumLeft,
  output logic [1:0]    Cause
);

  typedef enum logic [2:0] {S_OS, S_ENTER, S_PROC, S_SAVE, S_EXIT} state_t;

  localparam logic [QW-1:0] QZERO = '0;
  localparam logic [QW-1:0] QONE  = QW'(1);
  localparam logic [QW-1:0] QDEF  = QW'(DEF_QUANTUM);

  state_t        state_q, state_d;
  logic [31:0]   pctarget_q, pctarget_d;
  logic [31:0]   savedpc_q, savedpc_d;
  logic [QW-1:0] quantum_q, quantum_d;
  logic [1:0]    cause_q, cause_d;
  logic          exit_evt;

  assign exit_evt = EndProcIn | Syscall | (quantum_q == QONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_OS;
      pctarget_q <= '0;
      savedpc_q  <= '0;
      quantum_q  <= '0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      pctarget_q <= pctarget_d;
      savedpc_q  <= savedpc_d;
      quantum_q  <= quantum_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pctarget_d = pctarget_q;
    savedpc_d  = savedpc_q;
    quantum_d  = quantum_q;
    cause_d    = cause_q;
    case (state_q)
      S_OS: begin
        if (ResumeProc) begin
          state_d    = S_ENTER;
          pctarget_d = ResumeAddr;
          quantum_d  = (QuantumIn == QZERO) ? QDEF : QuantumIn;
        end
      end
      S_ENTER: state_d = S_PROC;
      S_PROC: begin
        if (quantum_q != QZERO) quantum_d = quantum_q - QONE;
        // The event instruction retires, so execution resumes after it.
        if (exit_evt) begin
          state_d   = S_SAVE;
          savedpc_d = ProgramCounter + 32'd1;
          if (EndProcIn)    cause_d = 2'b11;
          else if (Syscall) cause_d = 2'b10;
          else              cause_d = 2'b01;
        end
      end
      S_SAVE: begin
        state_d    = S_EXIT;
        pctarget_d = OS_VECTOR;
      end
      S_EXIT:  state_d = S_OS;
      default: state_d = S_OS;
    endcase
  end

  always_comb begin
    Stall                 = 1'b0;
    PcLoad                = 1'b0;
    select_proc_reg_read  = 1'b0;
    select_proc_reg_write = 1'b0;
    change_so             = 1'b0;
    end_proc              = 1'b0;
    WriteGate             = 1'b1;
    case (state_q)
      S_ENTER: begin
        Stall                 = 1'b1;
        PcLoad                = 1'b1;
        select_proc_reg_read  = 1'b1;
        select_proc_reg_write = 1'b1;
        WriteGate             = 1'b0;
      end
      S_PROC: begin
        select_proc_reg_read  = 1'b1;
        select_proc_reg_write = 1'b1;
      end
      // Read still sees the program bank while the save lands in the OS bank.
      S_SAVE: begin
        Stall                 = 1'b1;
        select_proc_reg_read  = 1'b1;
        change_so             = 1'b1;
        end_proc              = (cause_q == 2'b11);
        WriteGate             = 1'b0;
      end
      S_EXIT: begin
        Stall                 = 1'b1;
        PcLoad                = 1'b1;
        WriteGate             = 1'b0;
      end
      default: ;
    endcase
  end

  assign PcTarget    = pctarget_q;
  assign SavedPc     = savedpc_q;
  assign QuantumLeft = quantum_q;
  assign Cause       = cause_q;

endmodule

// File: tb/tb_context_switch_ctrl.sv
// Directed bench for context_switch_ctrl: switch sequencing, quantum, exit causes, reset.
module tb_context_switch_ctrl;
  localparam int          QW  = 16;
  localparam logic [31:0] OSV = 32'h0000_0100;

  // Control word order: Stall, PcLoad, sel_read, sel_write, change_so, end_proc, WriteGate
  localparam logic [6:0] C_OS    = 7'b0000001;
  localparam logic [6:0] C_ENTER = 7'b1111000;
  localparam logic [6:0] C_PROC  = 7'b0011001;
  localparam logic [6:0] C_SAVE  = 7'b1010100;
  localparam logic [6:0] C_SAVEE = 7'b1010110;
  localparam logic [6:0] C_EXIT  = 7'b1100000;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          ResumeProc = 1'b0;
  logic [31:0]   ResumeAddr = '0;
  logic [QW-1:0] QuantumIn = '0;
  logic [31:0]   ProgramCounter = '0;
  logic          Syscall = 1'b0;
  logic          EndProcIn = 1'b0;
  logic          Stall, PcLoad, select_proc_reg_read, select_proc_reg_write;
  logic          change_so, end_proc, WriteGate;
  logic [31:0]   PcTarget, SavedPc;
  logic [QW-1:0] QuantumLeft;
  logic [1:0]    Cause;

  int tests = 0;
  int fails = 0;

  context_switch_ctrl #(.QW(QW), .DEF_QUANTUM(1000), .OS_VECTOR(OSV)) dut (
    .Clock(Clock), .Reset(Reset), .ResumeProc(ResumeProc), .ResumeAddr(ResumeAddr),
    .QuantumIn(QuantumIn), .ProgramCounter(ProgramCounter), .Syscall(Syscall),
    .EndProcIn(EndProcIn), .Stall(Stall), .PcLoad(PcLoad), .PcTarget(PcTarget),
    .SavedPc(SavedPc), .select_proc_reg_read(select_proc_reg_read),
    .select_proc_reg_write(select_proc_reg_write), .change_so(change_so),
    .end_proc(end_proc), .WriteGate(WriteGate), .QuantumLeft(QuantumLeft), .Cause(Cause)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] ctl();
    return {Stall, PcLoad, select_proc_reg_read, select_proc_reg_write,
            change_so, end_proc, WriteGate};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issues a resume pulse from OS; returns positioned in ENTER with ResumeProc low.
  task automatic start_proc(input logic [31:0] addr, input logic [QW-1:0] q);
    ResumeProc = 1'b1;
    ResumeAddr = addr;
    QuantumIn  = q;
    step();
    ResumeProc = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) step();
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl(), C_OS); end
    tests++; if (PcTarget !== 32'h0 || SavedPc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h/%h want 0/0", PcTarget, SavedPc); end
    tests++; if (QuantumLeft !== '0 || Cause !== 2'b00) begin fails++; $display("FAIL reset_q_cause got %0d/%b want 0/00", QuantumLeft, Cause); end
    Reset = 1'b1;
    step();
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL idle_os got %b want %b", ctl(), C_OS); end
  endtask

  task automatic test_quantum();
    start_proc(32'h40, 16'd5);
    tests++; if (ctl() !== C_ENTER) begin fails++; $display("FAIL q_enter_ctl got %b want %b", ctl(), C_ENTER); end
    tests++; if (PcTarget !== 32'h40) begin fails++; $display("FAIL q_enter_target got %h want 00000040", PcTarget); end
    tests++; if (QuantumLeft !== 16'd5) begin fails++; $display("FAIL q_enter_ql got %0d want 5", QuantumLeft); end
    step();
    for (int i = 0; i < 5; i++) begin
      tests++; if (ctl() !== C_PROC) begin fails++; $display("FAIL q_proc_ctl[%0d] got %b want %b", i, ctl(), C_PROC); end
      tests++; if (QuantumLeft !== 16'(5 - i)) begin fails++; $display("FAIL q_proc_ql[%0d] got %0d want %0d", i, QuantumLeft, 5 - i); end
      ProgramCounter = 32'h40 + 32'(i);
      step();
    end
    tests++; if (ctl() !== C_SAVE) begin fails++; $display("FAIL q_save_ctl got %b want %b", ctl(), C_SAVE); end
    tests++; if (Cause !== 2'b01) begin fails++; $display("FAIL q_save_cause got %b want 01", Cause); end
    tests++; if (SavedPc !== 32'h45) begin fails++; $display("FAIL q_save_pc got %h want 00000045", SavedPc); end
    tests++; if (QuantumLeft !== 16'd0) begin fails++; $display("FAIL q_save_ql got %0d want 0", QuantumLeft); end
    step();
    tests++; if (ctl() !== C_EXIT) begin fails++; $display("FAIL q_exit_ctl got %b want %b", ctl(), C_EXIT); end
    tests++; if (PcTarget !== OSV) begin fails++; $display("FAIL q_exit_target got %h want %h", PcTarget, OSV); end
    step();
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL q_back_os got %b want %b", ctl(), C_OS); end
    tests++; if (QuantumLeft !== 16'd0 || Cause !== 2'b01) begin fails++; $display("FAIL q_hold got %0d/%b want 0/01", QuantumLeft, Cause); end
  endtask

  task automatic test_default_syscall();
    start_proc(32'h44, 16'd0);
    tests++; if (QuantumLeft !== 16'd1000) begin fails++; $display("FAIL def_quantum got %0d want 1000", QuantumLeft); end
    step();
    step();
    tests++; if (QuantumLeft !== 16'd999) begin fails++; $display("FAIL def_decrement got %0d want 999", QuantumLeft); end
    ProgramCounter = 32'h47;
    Syscall = 1'b1;
    step();
    Syscall = 1'b0;
    tests++; if (ctl() !== C_SAVE) begin fails++; $display("FAIL sys_save_ctl got %b want %b", ctl(), C_SAVE); end
    tests++; if (SavedPc !== 32'h48) begin fails++; $display("FAIL sys_saved_pc got %h want 00000048", SavedPc); end
    tests++; if (Cause !== 2'b10) begin fails++; $display("FAIL sys_cause got %b want 10", Cause); end
    step();
    tests++; if (ctl() !== C_EXIT) begin fails++; $display("FAIL sys_exit_ctl got %b want %b", ctl(), C_EXIT); end
    step();
  endtask

  task automatic test_priority();
    start_proc(32'h200, 16'd1);
    step();
    tests++; if (ctl() !== C_PROC || QuantumLeft !== 16'd1) begin fails++; $display("FAIL pri_proc got %b/%0d want %b/1", ctl(), QuantumLeft, C_PROC); end
    ProgramCounter = 32'h200;
    EndProcIn = 1'b1;
    Syscall   = 1'b1;
    step();
    EndProcIn = 1'b0;
    Syscall   = 1'b0;
    tests++; if (ctl() !== C_SAVEE) begin fails++; $display("FAIL pri_save_ctl got %b want %b", ctl(), C_SAVEE); end
    tests++; if (Cause !== 2'b11) begin fails++; $display("FAIL pri_cause got %b want 11", Cause); end
    tests++; if (SavedPc !== 32'h201) begin fails++; $display("FAIL pri_saved_pc got %h want 00000201", SavedPc); end
    step();
    tests++; if (ctl() !== C_EXIT) begin fails++; $display("FAIL pri_exit_ctl got %b want %b", ctl(), C_EXIT); end
    step();
    tests++; if (ctl() !== C_OS || Cause !== 2'b11) begin fails++; $display("FAIL pri_os got %b/%b want %b/11", ctl(), Cause, C_OS); end
  endtask

  task automatic test_ignore_resume();
    start_proc(32'h80, 16'd3);
    step();
    ResumeProc = 1'b1;
    ResumeAddr = 32'h999;
    QuantumIn  = 16'd50;
    step();
    tests++; if (ctl() !== C_PROC || QuantumLeft !== 16'd2) begin fails++; $display("FAIL ign_proc got %b/%0d want %b/2", ctl(), QuantumLeft, C_PROC); end
    step();
    tests++; if (ctl() !== C_PROC || QuantumLeft !== 16'd1) begin fails++; $display("FAIL ign_proc2 got %b/%0d want %b/1", ctl(), QuantumLeft, C_PROC); end
    step();
    tests++; if (ctl() !== C_SAVE || PcTarget !== 32'h80) begin fails++; $display("FAIL ign_save got %b/%h want %b/00000080", ctl(), PcTarget, C_SAVE); end
    step();
    tests++; if (ctl() !== C_EXIT || PcTarget !== OSV) begin fails++; $display("FAIL ign_exit got %b/%h want %b/%h", ctl(), PcTarget, C_EXIT, OSV); end
    step();
    ResumeProc = 1'b0;
    tests++; if (ctl() !== C_OS || QuantumLeft !== 16'd0) begin fails++; $display("FAIL ign_os got %b/%0d want %b/0", ctl(), QuantumLeft, C_OS); end
    step();
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL ign_stay_os got %b want %b", ctl(), C_OS); end
  endtask

  task automatic test_pc_wrap();
    start_proc(32'h300, 16'd10);
    step();
    ProgramCounter = 32'hFFFF_FFFF;
    Syscall = 1'b1;
    step();
    Syscall = 1'b0;
    tests++; if (SavedPc !== 32'h0 || Cause !== 2'b10) begin fails++; $display("FAIL wrap_saved_pc got %h/%b want 00000000/10", SavedPc, Cause); end
    step();
    step();
  endtask

  task automatic test_reset_mid_save();
    start_proc(32'h500, 16'd2);
    step();
    step();
    step();
    tests++; if (ctl() !== C_SAVE || Cause !== 2'b01) begin fails++; $display("FAIL rs_pre_save got %b/%b want %b/01", ctl(), Cause, C_SAVE); end
    Reset = 1'b0;
    #2;
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL rs_ctl got %b want %b", ctl(), C_OS); end
    tests++; if (Cause !== 2'b00 || SavedPc !== 32'h0) begin fails++; $display("FAIL rs_cause_pc got %b/%h want 00/00000000", Cause, SavedPc); end
    tests++; if (QuantumLeft !== '0 || PcTarget !== 32'h0) begin fails++; $display("FAIL rs_q_target got %0d/%h want 0/00000000", QuantumLeft, PcTarget); end
    step();
    Reset = 1'b1;
    step();
    tests++; if (ctl() !== C_OS) begin fails++; $display("FAIL rs_after got %b want %b", ctl(), C_OS); end
  endtask

  initial begin
    test_reset();
    test_quantum();
    test_default_syscall();
    test_priority();
    test_ignore_resume();
    test_pc_wrap();
    test_reset_mid_save();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
